// File: rtl/pipe_perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package pipe_perf_pkg;

  // Run FSM: counts only while in RUN with start_i high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  // Snapshot stream FSM.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } snap_state_t;

  // Counter overflow behaviour.
  localparam int WRAP = 0;
  localparam int SAT  = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_perf_monitor_counter_cell.sv
// One counter with a sticky overflow flag; wraps or saturates on overflow.
module perf_counter_cell
  import pipe_perf_pkg::*;
#(
  parameter int W        = 32,
  parameter int SAT_MODE = WRAP
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  // Clear wins over a coincident increment; overflow is sticky until clear/reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (inc_i) begin
      if (&cnt_o) begin
        ovf_o <= 1'b1;
        cnt_o <= (SAT_MODE == SAT) ? cnt_o : '0;
      end else begin
        cnt_o <= cnt_o + W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle counter plus N_EVT event counters,
// a cycle budget, and a frozen snapshot streamed over a valid/ready port.
//
// Stream handshake: rd_valid_o/rd_idx_o/rd_data_o stay stable until a cycle
// with rd_valid_o & rd_ready_i, which transfers the word; the next word
// appears on the following cycle. rd_valid_o never depends on rd_ready_i.
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter  int N_EVT      = 2,
  parameter  int CNT_W      = 32,
  parameter  int CYC_W      = 32,
  parameter  int SAT_MODE   = WRAP,
  parameter  int MAX_CYCLES = 30,
  localparam int IDX_W      = $clog2(N_EVT + 1),
  localparam int DW         = max_int(CNT_W, CYC_W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic             snap_req_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic [DW-1:0]    rd_data_o,
  output logic             snap_busy_o,
  output logic [CYC_W-1:0] cycle_o,
  output logic             done_o,
  output logic [N_EVT:0]   ovf_o,
  output logic [1:0]       dbg_run_state_o,
  output logic             dbg_snap_state_o
);

  run_state_t  run_q, run_d;
  snap_state_t snap_q, snap_d;

  logic             counting;
  logic             budget_hit;
  logic             capture;
  logic             accept;
  logic             last_word;
  logic [CYC_W-1:0] cyc_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [DW-1:0]    cnt_ext [N_EVT+1];
  logic [DW-1:0]    shadow  [N_EVT+1];

  assign counting = (run_q == RUN) && start_i;

  // Budget reached when this counting edge makes the cycle counter equal
  // MAX_CYCLES; a saturated counter can never get there.
  assign budget_hit = (MAX_CYCLES > 0) && !(&cyc_cnt) &&
                      ((64'(cyc_cnt) + 64'd1) == 64'(MAX_CYCLES));

  // Counter bank: index 0 is the cycle counter, index k is event k-1.
  for (genvar k = 0; k <= N_EVT; k++) begin : g_cnt
    if (k == 0) begin : g_cyc
      logic [CYC_W-1:0] c;
      perf_counter_cell #(.W(CYC_W), .SAT_MODE(SAT_MODE)) u_cell (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(counting), .clr_i(clear_i),
        .cnt_o(c), .ovf_o(ovf_o[k])
      );
      assign cnt_ext[k] = DW'(c);
      assign cyc_cnt    = c;
    end else begin : g_evt
      logic [CNT_W-1:0] c;
      perf_counter_cell #(.W(CNT_W), .SAT_MODE(SAT_MODE)) u_cell (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(counting && evt_i[k-1]), .clr_i(clear_i),
        .cnt_o(c), .ovf_o(ovf_o[k])
      );
      assign cnt_ext[k] = DW'(c);
    end
  end

  // Run FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) run_q <= IDLE;
    else       run_q <= run_d;
  end

  // Run FSM next state; clear forces IDLE, DONE is left only by clear/reset.
  always_comb begin
    run_d = run_q;
    if (clear_i) begin
      run_d = IDLE;
    end else begin
      case (run_q)
        IDLE:    if (start_i) run_d = RUN;
        RUN:     if (!start_i) run_d = IDLE;
                 else if (budget_hit) run_d = DONE;
        DONE:    run_d = DONE;
        default: run_d = IDLE;
      endcase
    end
  end

  assign capture   = (snap_q == S_IDLE) && snap_req_i;
  assign accept    = (snap_q == S_STREAM) && rd_ready_i;
  assign last_word = (idx_q == IDX_W'(N_EVT));

  // Stream FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) snap_q <= S_IDLE;
    else       snap_q <= snap_d;
  end

  // Stream FSM next state; requests during a stream are ignored.
  always_comb begin
    snap_d = snap_q;
    case (snap_q)
      S_IDLE:   if (snap_req_i) snap_d = S_STREAM;
      S_STREAM: if (accept && last_word) snap_d = S_IDLE;
      default:  snap_d = S_IDLE;
    endcase
  end

  // Word index: restarts at 0 on capture, advances on each accepted word.
  always_ff @(posedge clk_i) begin
    if (rst_i)        idx_q <= '0;
    else if (capture) idx_q <= '0;
    else if (accept)  idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
  end

  // Shadow registers take the pre-update counter values on the capture edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= N_EVT; k++) shadow[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k <= N_EVT; k++) shadow[k] <= cnt_ext[k];
    end
  end

  // Stream data mux over the shadow array.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k <= N_EVT; k++) begin
      if (idx_q == IDX_W'(k)) rd_data_o = shadow[k];
    end
  end

  assign rd_valid_o       = (snap_q == S_STREAM);
  assign snap_busy_o      = rd_valid_o;
  assign rd_idx_o         = idx_q;
  assign cycle_o          = cyc_cnt;
  assign done_o           = (run_q == DONE);
  assign dbg_run_state_o  = run_q;
  assign dbg_snap_state_o = snap_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor with a scoreboard on the snapshot stream.
`timescale 1ns/1ps
module tb_pipe_perf_monitor;
  import pipe_perf_pkg::*;

  localparam int IDX_W = 2;
  localparam int DW    = 32;
  localparam int W     = IDX_W + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic             start, clear, snap, ready;
  logic [1:0]       evt;
  logic             rd_valid, busy, done, dbg_snap;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rd_data;
  logic [31:0]      cycle;
  logic [2:0]       ovf;
  logic [1:0]       dbg_run;

  pipe_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .snap_req_i(snap), .rd_ready_i(ready), .rd_valid_o(rd_valid), .rd_idx_o(rd_idx),
    .rd_data_o(rd_data), .snap_busy_o(busy), .cycle_o(cycle), .done_o(done),
    .ovf_o(ovf), .dbg_run_state_o(dbg_run), .dbg_snap_state_o(dbg_snap)
  );

  // ---------------- narrow counters, saturating and wrapping ----------------
  logic             s_start, s_snap, s_ready;
  logic [1:0]       s_evt;
  logic             sat_valid, sat_busy, sat_done, sat_dbg_snap;
  logic             wrp_valid, wrp_busy, wrp_done, wrp_dbg_snap;
  logic [IDX_W-1:0] sat_idx, wrp_idx;
  logic [DW-1:0]    sat_data, wrp_data;
  logic [31:0]      sat_cycle, wrp_cycle;
  logic [2:0]       sat_ovf, wrp_ovf;
  logic [1:0]       sat_dbg_run, wrp_dbg_run;

  pipe_perf_monitor #(.CNT_W(4), .SAT_MODE(SAT), .MAX_CYCLES(0)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(1'b0), .evt_i(s_evt),
    .snap_req_i(s_snap), .rd_ready_i(s_ready), .rd_valid_o(sat_valid), .rd_idx_o(sat_idx),
    .rd_data_o(sat_data), .snap_busy_o(sat_busy), .cycle_o(sat_cycle), .done_o(sat_done),
    .ovf_o(sat_ovf), .dbg_run_state_o(sat_dbg_run), .dbg_snap_state_o(sat_dbg_snap)
  );

  pipe_perf_monitor #(.CNT_W(4), .SAT_MODE(WRAP), .MAX_CYCLES(0)) dut_wrp (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(1'b0), .evt_i(s_evt),
    .snap_req_i(s_snap), .rd_ready_i(s_ready), .rd_valid_o(wrp_valid), .rd_idx_o(wrp_idx),
    .rd_data_o(wrp_data), .snap_busy_o(wrp_busy), .cycle_o(wrp_cycle), .done_o(wrp_done),
    .ovf_o(wrp_ovf), .dbg_run_state_o(wrp_dbg_run), .dbg_snap_state_o(wrp_dbg_snap)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sat_q[$];
  logic [W-1:0] wrp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] wd(input int i, input logic [31:0] d);
    logic [1:0] ii;
    ii = i[1:0];
    return {ii, d};
  endfunction

  // which: 0 = main, 1 = saturating, 2 = wrapping
  task automatic push3(input int which, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    case (which)
      0: begin exp_q.push_back(wd(0, a)); exp_q.push_back(wd(1, b)); exp_q.push_back(wd(2, c)); end
      1: begin sat_q.push_back(wd(0, a)); sat_q.push_back(wd(1, b)); sat_q.push_back(wd(2, c)); end
      default: begin wrp_q.push_back(wd(0, a)); wrp_q.push_back(wd(1, b)); wrp_q.push_back(wd(2, c)); end
    endcase
  endtask

  // Monitors: every valid cycle must show the head of the queue; pop on transfer.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL stream_extra: got idx %0d data %0h, required no word", rd_idx, rd_data);
      end else begin
        chk("stream_word", {rd_idx, rd_data}, exp_q[0]);
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (sat_valid) begin
      if (sat_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sat_stream_extra: got idx %0d data %0h, required no word", sat_idx, sat_data);
      end else begin
        chk("sat_stream_word", {sat_idx, sat_data}, sat_q[0]);
        if (s_ready) void'(sat_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (wrp_valid) begin
      if (wrp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wrap_stream_extra: got idx %0d data %0h, required no word", wrp_idx, wrp_data);
      end else begin
        chk("wrap_stream_word", {wrp_idx, wrp_data}, wrp_q[0]);
        if (s_ready) void'(wrp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    start = 0; clear = 0; evt = 0; snap = 0; ready = 0;
    s_start = 0; s_evt = 0; s_snap = 0; s_ready = 0;
    rst = 1;
    tick(2);

    // reset state
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_idx", rd_idx, 0);
    chk("rst_run_state", dbg_run, IDLE);
    rst = 0;

    // 1: budget of 30 cycles, evt0 on run cycles 3,4 and evt1 on cycle 7
    start = 1; tick();
    chk("t1_enter_run", dbg_run, RUN);
    for (int n = 1; n <= 30; n++) begin
      evt = {n == 7, (n == 3) || (n == 4)};
      tick();
      chk("t1_cycle", cycle, n);
      chk("t1_done", done, n == 30);
    end
    evt = 2'b11; tick(3); evt = 0;
    chk("t1_cycle_after_done", cycle, 30);
    chk("t1_done_held", done, 1);
    chk("t1_state_done", dbg_run, DONE);
    chk("t1_ovf", ovf, 0);
    push3(0, 30, 2, 1);
    snap = 1; tick(); snap = 0;
    ready = 1; tick(3); ready = 0;
    chk("t1_busy_end", busy, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // 3: snapshot at cycle 10 with ready toggling and a second request mid-stream
    clear = 1; tick(); clear = 0;
    chk("t3_clear_cycle", cycle, 0);
    chk("t3_clear_done", done, 0);
    chk("t3_clear_state", dbg_run, IDLE);
    tick();
    chk("t3_resume_run", dbg_run, RUN);
    for (int n = 1; n <= 10; n++) begin
      evt = {n == 9, (n == 2) || (n == 5) || (n == 6)};
      tick();
    end
    chk("t3_cycle10", cycle, 10);
    push3(0, 10, 3, 1);
    snap = 1; evt = 2'b01; tick(); snap = 0; evt = 0;
    for (int i = 0; i <= 4; i++) begin
      ready = (i % 2 == 0);
      snap  = (i == 1);
      tick();
      chk("t3_busy", busy, i < 4);
    end
    ready = 0; snap = 0;
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_cycle16", cycle, 16);

    // 4: clear + snapshot + event in one cycle
    push3(0, 16, 4, 1);
    clear = 1; snap = 1; evt = 2'b01; tick();
    clear = 0; snap = 0; evt = 0; start = 0;
    chk("t4_live_cycle0", cycle, 0);
    chk("t4_state_idle", dbg_run, IDLE);
    chk("t4_busy", busy, 1);
    ready = 1; tick(3);
    chk("t4_busy_end", busy, 0);
    chk("t4_q_empty", exp_q.size(), 0);
    push3(0, 0, 0, 0);
    snap = 1; tick(); snap = 0; tick(3);
    chk("t4_busy_end2", busy, 0);
    chk("t4_q_empty2", exp_q.size(), 0);
    ready = 0;

    // 5: pause for 5 cycles and resume
    start = 1; tick();
    chk("t5_run", dbg_run, RUN);
    evt = 2'b10; tick(4);
    chk("t5_cycle4", cycle, 4);
    start = 0; evt = 2'b11; tick();
    chk("t5_paused_state", dbg_run, IDLE);
    chk("t5_paused_cycle", cycle, 4);
    tick(4);
    chk("t5_frozen_cycle", cycle, 4);
    chk("t5_frozen_state", dbg_run, IDLE);
    start = 1; evt = 2'b01; tick();
    chk("t5_restart_cycle", cycle, 4);
    chk("t5_restart_state", dbg_run, RUN);
    tick(3);
    chk("t5_cycle7", cycle, 7);
    start = 0; evt = 0;
    push3(0, 7, 3, 4);
    snap = 1; tick(); snap = 0;
    ready = 1; tick(3); ready = 0;
    chk("t5_busy_end", busy, 0);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: reset while streaming in DONE
    start = 1; tick();
    tick(22);
    chk("t6_cycle29", cycle, 29);
    chk("t6_not_done", done, 0);
    tick();
    chk("t6_cycle30", cycle, 30);
    chk("t6_done", done, 1);
    push3(0, 30, 3, 4);
    snap = 1; tick(); snap = 0;
    chk("t6_streaming", rd_valid, 1);
    rst = 1; tick();
    exp_q.delete();
    chk("t6_valid", rd_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done_rst", done, 0);
    chk("t6_cycle_rst", cycle, 0);
    chk("t6_ovf_rst", ovf, 0);
    chk("t6_idx_rst", rd_idx, 0);
    chk("t6_data_rst", rd_data, 0);
    chk("t6_state_rst", dbg_run, IDLE);
    rst = 0; start = 0;
    tick(2);
    chk("t6_stay_idle", rd_valid, 0);

    // 2: 4-bit counters, evt0 held for 20 counting cycles
    s_start = 1; tick();
    s_evt = 2'b01; tick(20);
    s_evt = 0; s_start = 0;
    chk("t2_sat_ovf", sat_ovf, 3'b010);
    chk("t2_wrap_ovf", wrp_ovf, 3'b010);
    chk("t2_sat_cycle", sat_cycle, 20);
    chk("t2_wrap_cycle", wrp_cycle, 20);
    chk("t2_sat_no_done", sat_done, 0);
    push3(1, 20, 15, 0);
    push3(2, 20, 4, 0);
    s_snap = 1; tick(); s_snap = 0;
    s_ready = 1; tick(3); s_ready = 0;
    chk("t2_sat_busy_end", sat_busy, 0);
    chk("t2_wrap_busy_end", wrp_busy, 0);
    chk("t2_sat_q_empty", sat_q.size(), 0);
    chk("t2_wrap_q_empty", wrp_q.size(), 0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #200000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
